shift_seq16: RTL and testbench
==============================

Name: shift_seq16

Overview:
- Command sequencer directly upstream of the 16-bit single-step shifter (shifter16).
- Accepts a multi-bit shift command over a valid/ready handshake and drives the shifter's data_in/control for one load step plus N single-bit steps.
- Between steps it feeds the shifter's registered data_out back to its data_in, then returns the final word over a valid/ready result handshake.

Parameters:
WIDTH, 16, data word width (must match the shifter)
AMT_W, 4, shift-amount width; amounts 0..2^AMT_W-1

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  reset, synchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer accepts command this cycle
cmd_data  input  WIDTH  word to shift
cmd_dir  input  2  01 = left, 10 = right; 00/11 = no shift (load only)
cmd_amount  input  AMT_W  number of single-bit steps
shf_q  input  WIDTH  shifter data_out (feedback)
shf_data  output  WIDTH  to shifter data_in
shf_ctrl  output  2  to shifter control
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  WIDTH  final shifted word

Behaviour:
- Shifter control codes, fixed and decided:
  - 00 = hold.
  - 01 = q <= {d[W-2:0],0}.
  - 10 = q <= {0,d[W-1:1]}.
  - 11 = q <= d (load).
  - The shifter has one cycle of latency.
- Reset, sampled on clk while reset_n = 0:
  - State goes to IDLE.
  - Counter, cmd_ready, res_valid, shf_ctrl and shf_data are all 0.
  - cmd_ready rises in the first cycle after reset_n = 1.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1, shf_ctrl = 00.
  - On cmd_valid & cmd_ready: register data, dir and amount, then go to LOAD.
- LOAD (exactly 1 cycle):
  - shf_data = registered cmd_data, shf_ctrl = 11.
  - Next state is SHIFT if amount != 0 and dir is 01 or 10; otherwise DONE.
- SHIFT:
  - shf_data = shf_q (combinational feedback), shf_ctrl = registered dir.
  - Down-counter loads amount on entry and decrements once per cycle.
  - Exactly amount cycles are spent in SHIFT, then go to DONE.
- DONE:
  - shf_ctrl = 00, so the shifter holds.
  - res_valid = 1, res_data = shf_q, stable until taken.
  - On res_ready go to IDLE.
  - cmd_ready = 0 in DONE; commands are not overlapped.
- shf_data is 0 in IDLE and DONE.
- Latency from the accept edge to res_valid high:
  - amount + 2 cycles for a shift command.
  - 2 cycles for load-only.
- Throughput: at most one command per latency + 1 cycles.
- cmd_ready = 0 outside IDLE; cmd_valid in those states is ignored and not queued.
- Amount 15: the SHIFT count must not wrap. A count of 0 only at entry is impossible because that case bypasses SHIFT.
- Reset mid-operation:
  - Immediate return to IDLE on the next edge; the in-flight command is dropped.
  - The shifter shares reset_n and clears in the same cycle.
- All outputs are driven from registered state, except shf_data in SHIFT and res_data in DONE, which pass shf_q through.

Decomposition:
- Package shift_seq_pkg:
  - Control-code localparams CTRL_HOLD = 2'b00, CTRL_SHL = 2'b01, CTRL_SHR = 2'b10, CTRL_LOAD = 2'b11.
  - State enum typedef seq_state_t.
  - Both are shared with the shifter's verification bench.
- No sub-module: the FSM plus the down-counter is a single module.
- The shifter instance lives in the enclosing datapath, not inside this block.

Test Plan:
1. cmd 0x8001, dir 01, amt 1 -> res_valid on the 3rd cycle after accept, res_data = 0x0002; shf_ctrl sequence 11, 01, 00.
2. cmd 0xF0F0, dir 10, amt 4 -> res_data = 0x0F0F, latency 6; exactly four cycles with shf_ctrl = 10.
3. cmd 0x0001, dir 01, amt 15 -> res_data = 0x8000, latency 17; counter does not wrap; a following cmd 0x8000 dir 10 amt 15 -> 0x0001.
4. Load-only cases, each with latency 2:
   - amt 0, cmd 0x1234, dir 01 -> 0x1234.
   - dir 11, amt 7, cmd 0xBEEF -> 0xBEEF.
5. res_ready held low 5 cycles in DONE -> res_data constant, shf_ctrl = 00, cmd_ready = 0, and a concurrent cmd_valid is not accepted; on res_ready = 1 -> IDLE next cycle.
6. reset_n low for 1 cycle during SHIFT of cmd 0xAAAA dir 01 amt 8 -> next cycle all outputs 0 / IDLE; then cmd 0x00FF dir 01 amt 8 -> 0xFF00.

Source files
------------

// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_pkg
//  Description : Shared shifter control codes and sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

  // Shifter control codes (one-cycle-latency shifter16)
  localparam logic [1:0] CTRL_HOLD = 2'b00;  // q <= q
  localparam logic [1:0] CTRL_SHL  = 2'b01;  // q <= {d[W-2:0],0}
  localparam logic [1:0] CTRL_SHR  = 2'b10;  // q <= {0,d[W-1:1]}
  localparam logic [1:0] CTRL_LOAD = 2'b11;  // q <= d

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_seq16.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq16
//  Description : Multi-bit shift command sequencer driving a single-step
//                shifter: one load step, then N single-bit steps with the
//                shifter output fed back, then a result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_seq16
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [1:0]       cmd_dir,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] shf_q,
  output logic [WIDTH-1:0] shf_data,
  output logic [1:0]       shf_ctrl,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  seq_state_t       state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       dir_q, dir_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       shf_ctrl_q, shf_ctrl_d;
  logic             shift_cmd;

  // Only a non-zero amount with a real direction needs the SHIFT phase
  assign shift_cmd = (amt_q != '0) && ((dir_q == CTRL_SHL) || (dir_q == CTRL_SHR));

  // Next-state, command capture and down-counter; registered outputs are
  // derived from the next state so they line up with the state register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    dir_d       = dir_q;
    amt_d       = amt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          amt_d   = cmd_amount;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (shift_cmd) begin
          cnt_d   = amt_q;
          state_d = S_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        // Counter holds remaining steps including the current one, so it
        // never decrements below zero even for the maximum amount
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_DONE);
    case (state_d)
      S_LOAD:  shf_ctrl_d = CTRL_LOAD;
      S_SHIFT: shf_ctrl_d = dir_d;
      default: shf_ctrl_d = CTRL_HOLD;
    endcase
  end

  // State, captured command, counter and output registers; reset drops any
  // in-flight command
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      dir_q       <= CTRL_HOLD;
      amt_q       <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      shf_ctrl_q  <= CTRL_HOLD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      amt_q       <= amt_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      shf_ctrl_q  <= shf_ctrl_d;
    end
  end

  // Shifter data mux: captured word for the load step, feedback while shifting
  always_comb begin
    shf_data = '0;
    case (state_q)
      S_LOAD:  shf_data = data_q;
      S_SHIFT: shf_data = shf_q;
      default: shf_data = '0;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign shf_ctrl  = shf_ctrl_q;
  assign res_data  = res_valid_q ? shf_q : '0;

endmodule : shift_seq16
`default_nettype wire

// File: tb/tb_shift_seq16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq16
//  Description : Directed self-checking bench for shift_seq16 with a
//                behavioural single-step shifter closing the feedback loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_seq16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_dir;
  logic [3:0]  cmd_amount;
  logic [15:0] shf_q;
  logic [15:0] shf_data;
  logic [1:0]  shf_ctrl;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;

  int checks = 0;
  int errors = 0;

  shift_seq16 #(.WIDTH(16), .AMT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_amount (cmd_amount),
    .shf_q      (shf_q),
    .shf_data   (shf_data),
    .shf_ctrl   (shf_ctrl),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  always #5 clk = ~clk;

  // Behavioural shifter16 sharing the sequencer reset
  always @(posedge clk) begin
    if (!reset_n) shf_q <= 16'h0000;
    else begin
      case (shf_ctrl)
        2'b01:   shf_q <= {shf_data[14:0], 1'b0};
        2'b10:   shf_q <= {1'b0, shf_data[15:1]};
        2'b11:   shf_q <= shf_data;
        default: shf_q <= shf_q;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle; returns just after the accept edge
  task automatic send(input logic [15:0] d, input logic [1:0] dir, input logic [3:0] amt);
    chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_dir    = dir;
    cmd_amount = amt;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Follow one command to DONE, checking latency, step counts and result
  task automatic run_check(input string tag, input logic [3:0] amt_steps, input int exp_lat,
                           input logic [15:0] exp_res);
    int lat;
    int n_shift;
    int n_load;
    logic [1:0] first_ctrl;
    lat = 1;
    n_shift = 0;
    n_load = 0;
    first_ctrl = shf_ctrl;
    while (!res_valid && lat < 40) begin
      if (shf_ctrl == 2'b11) n_load++;
      if (shf_ctrl == 2'b01 || shf_ctrl == 2'b10) n_shift++;
      tick();
      lat++;
    end
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_first_ctrl"}, {30'd0, first_ctrl}, 32'd3);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_load_steps"}, n_load, 1);
    chk({tag, "_shift_steps"}, n_shift, {28'd0, amt_steps});
    chk({tag, "_res_data"}, {16'd0, res_data}, {16'd0, exp_res});
    chk({tag, "_done_ctrl"}, {30'd0, shf_ctrl}, 32'd0);
    chk({tag, "_done_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_done_shf_data"}, {16'd0, shf_data}, 32'd0);
  endtask

  // Take the result and confirm return to IDLE
  task automatic take(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_idle_res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_idle_ctrl"}, {30'd0, shf_ctrl}, 32'd0);
  endtask

  logic [15:0] held;

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_data   = 16'h0000;
    cmd_dir    = 2'b00;
    cmd_amount = 4'd0;
    res_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_shf_ctrl", {30'd0, shf_ctrl}, 32'd0);
    chk("rst_shf_data", {16'd0, shf_data}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: left by 1
    send(16'h8001, 2'b01, 4'd1);
    run_check("t1", 4'd1, 3, 16'h0002);
    take("t1");

    // 2: right by 4
    send(16'hF0F0, 2'b10, 4'd4);
    run_check("t2", 4'd4, 6, 16'h0F0F);
    take("t2");

    // 3: maximum amount both directions
    send(16'h0001, 2'b01, 4'd15);
    run_check("t3a", 4'd15, 17, 16'h8000);
    take("t3a");
    send(16'h8000, 2'b10, 4'd15);
    run_check("t3b", 4'd15, 17, 16'h0001);
    take("t3b");

    // 4: load-only
    send(16'h1234, 2'b01, 4'd0);
    run_check("t4a", 4'd0, 2, 16'h1234);
    take("t4a");
    send(16'hBEEF, 2'b11, 4'd7);
    run_check("t4b", 4'd0, 2, 16'hBEEF);
    take("t4b");

    // 5: consumer stalls in DONE while another command is offered
    send(16'h0F00, 2'b10, 4'd2);
    run_check("t5", 4'd2, 4, 16'h03C0);
    held = res_data;
    cmd_valid  = 1'b1;
    cmd_data   = 16'hDEAD;
    cmd_dir    = 2'b01;
    cmd_amount = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_data", {16'd0, res_data}, {16'd0, held});
      chk("t5_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t5_hold_ctrl", {30'd0, shf_ctrl}, 32'd0);
      chk("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    take("t5");
    tick();
    chk("t5_no_queued_cmd", {30'd0, shf_ctrl}, 32'd0);
    chk("t5_still_idle", {31'd0, cmd_ready}, 32'd1);

    // 6: reset during SHIFT, then a fresh command
    send(16'hAAAA, 2'b01, 4'd8);
    tick();
    tick();
    chk("t6_in_shift_ctrl", {30'd0, shf_ctrl}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_rst_ctrl", {30'd0, shf_ctrl}, 32'd0);
    chk("t6_rst_shf_data", {16'd0, shf_data}, 32'd0);
    chk("t6_rst_res_data", {16'd0, res_data}, 32'd0);
    tick();
    chk("t6_post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    send(16'h00FF, 2'b01, 4'd8);
    run_check("t6", 4'd8, 10, 16'hFF00);
    take("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_seq16
`default_nettype wire
